mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle MIPS control unit: successor to the single-cycle decoder, driving a shared-memory multi-cycle datapath.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states; supports memory wait-states and cycle/retire counters.
//  Decodes the same instruction set: add sub and or slt sltu addu subu sll nor addi ori lw sw beq bne lui slti j jal.
//  Op/Funct come from the external IR, which holds them stable from DECODE until the next FETCH completes.
// PARAMETERS
//  ALUOP_W    4   ALUOp width; codes NOP=0 ADD=1 SUB=2 AND=3 OR=4 SLT=5 SLTU=6 SLL=7 LUI=8, NOR=8 w/ funct (unchanged encoding)
//  MEM_HS     1   1: FETCH/MEMRD/MEMWR wait for mem_rdy; 0: memory treated as single-cycle (mem_rdy ignored)
//  CNT_W      32  width of cycle_cnt / instret_cnt
// PORTS
//  clk          in   1        clock, rising edge
//  rstn         in   1        asynchronous active-low reset
//  Op           in   6        IR opcode
//  Funct        in   6        IR funct
//  Zero         in   1        ALU zero flag
//  mem_rdy      in   1        memory access complete this cycle
//  PCWrite      out  1        PC load enable
//  IRWrite      out  1        IR load enable
//  RegWrite     out  1        register file write enable
//  MemRead      out  1        memory read request
//  MemWrite     out  1        memory write request
//  IorD         out  1        0: address=PC, 1: address=ALUOut
//  EXTOp        out  1        1: sign-extend imm16
//  ALUSrcA      out  1        0: PC, 1: rs data
//  ALUSrcB      out  2        00 rt data, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ALUOp        out  ALUOP_W  ALU operation
//  PCSource     out  2        00 ALU result, 01 ALUOut (branch target), 10 jump target
//  GPRSel       out  2        00 rd, 01 rt, 10 $31
//  WDSel        out  2        00 ALUOut, 01 MDR, 10 PC
//  illegal      out  1        one-cycle pulse: undecodable instruction in DECODE
//  state_o      out  4        current state encoding (debug)
//  cycle_cnt    out  CNT_W    cycles since reset
//  instret_cnt  out  CNT_W    instructions retired since reset
// BEHAVIOUR
//  State encoding: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 JUMP=9 IEXEC=10 IWB=11.
//  Outputs are Moore (state + Op/Funct); only state and counters are registered. Unlisted enables=0, selects=0.
//  rstn low: state=FETCH, counters=0, all enables (PCWrite IRWrite RegWrite MemRead MemWrite) and illegal forced 0 combinationally.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
//   Completion = mem_rdy (MEM_HS=1) or every cycle (MEM_HS=0). On completion: IRWrite=1, PCWrite=1, next DECODE; else hold FETCH.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, EXTOp=1 (branch target precomputed). Next state by type:
//   lw/sw -> MEMADR; R-type -> EXEC; addi/ori/lui/slti -> IEXEC; beq/bne -> BRANCH; j/jal -> JUMP.
//   Any other Op, or R-type with unlisted Funct: illegal=1, next FETCH, not retired.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, EXTOp=1; lw->MEMRD, sw->MEMWR.
//  MEMRD: MemRead=1, IorD=1; on completion -> MEMWB.
//   MEMWB: RegWrite=1, GPRSel=01, WDSel=01 -> FETCH.
//  MEMWR: MemWrite=1, IorD=1, held until completion -> FETCH.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp per funct -> ALUWB.
//   ALUWB: RegWrite=1, GPRSel=00, WDSel=00, ALUOp unchanged -> FETCH.
//  IEXEC: ALUSrcA=1, ALUSrcB=10, EXTOp=1 for addi/slti only, ALUOp ADD/OR/LUI/SLT -> IWB.
//   IWB: RegWrite=1, GPRSel=01, WDSel=00 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01; PCWrite=(beq&Zero)|(bne&~Zero) -> FETCH.
//  JUMP: PCSource=10, PCWrite=1; jal also RegWrite=1, GPRSel=10, WDSel=10 (PC already +4) -> FETCH.
//  cycle_cnt: +1 every clock out of reset. instret_cnt: +1 on each transition into FETCH, except from illegal DECODE.
//   Both counters wrap modulo 2^CNT_W.
//  Reset mid-instruction: any pending write is dropped; the next cycle after rstn rises is FETCH.
// TESTING
//  add (Op=0,Funct=0x20), MEM_HS=1, mem_rdy=1: states 0,1,6,7,0; RegWrite only in state 7; ALUOp=1; instret +1.
//  lw, mem_rdy low 2 cycles in MEMRD: MEMRD held 3 cycles; MemRead=IorD=1 throughout; one RegWrite pulse, WDSel=01.
//  beq, Zero=1 -> PCWrite=1, PCSource=01 in BRANCH; Zero=0 -> PCWrite=0; bne inverts both cases.
//  jal: JUMP asserts PCWrite, RegWrite, GPRSel=10, WDSel=10 in the same cycle; instruction total 3 cycles.
//  Op=0x3F: illegal pulses 1 cycle in DECODE, next FETCH, instret unchanged, cycle_cnt +2.
//  rstn low during MEMWR: MemWrite drops immediately; after release: state_o=0, counters=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
// states, stretches memory states on wait-states, and keeps cycle and retired-instruction counters.
module mc_ctrl #(
    parameter int ALUOP_W = 4,
    parameter bit MEM_HS  = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_rdy,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               EXTOp,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               illegal,
    output logic [3:0]         state_o,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0), ALU_ADD = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2), ALU_AND = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4), ALU_SLT = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(6), ALU_SLL = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(8);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cycle_q, instret_q;
    logic               mem_done, retire;
    logic               r_legal;
    logic [ALUOP_W-1:0] r_aluop;
    logic               pcw_c, irw_c, rw_c, mrd_c, mwr_c, ill_c;

    assign mem_done = MEM_HS ? mem_rdy : 1'b1;

    // NOR shares the LUI code; the ALU tells them apart by funct.
    always_comb begin
        r_legal = 1'b1;
        r_aluop = ALU_NOP;
        case (Funct)
            6'h20, 6'h21: r_aluop = ALU_ADD;
            6'h22, 6'h23: r_aluop = ALU_SUB;
            6'h24:        r_aluop = ALU_AND;
            6'h25:        r_aluop = ALU_OR;
            6'h27:        r_aluop = ALU_LUI;
            6'h2A:        r_aluop = ALU_SLT;
            6'h2B:        r_aluop = ALU_SLTU;
            6'h00:        r_aluop = ALU_SLL;
            default:      r_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pcw_c    = 1'b0;
        irw_c    = 1'b0;
        rw_c     = 1'b0;
        mrd_c    = 1'b0;
        mwr_c    = 1'b0;
        ill_c    = 1'b0;
        IorD     = 1'b0;
        EXTOp    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = ALU_NOP;
        PCSource = 2'b00;
        GPRSel   = 2'b00;
        WDSel    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mrd_c   = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                if (mem_done) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                EXTOp   = 1'b1;
                case (Op)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_ADDI, OP_ORI, OP_LUI, OP_SLTI: state_d = S_IEXEC;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J, OP_JAL:                     state_d = S_JUMP;
                    OP_RTYPE: begin
                        state_d = r_legal ? S_EXEC : S_FETCH;
                        ill_c   = ~r_legal;
                    end
                    default: begin
                        state_d = S_FETCH;
                        ill_c   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
                EXTOp   = 1'b1;
                state_d = (Op == OP_LW) ? S_MEMRD : ((Op == OP_SW) ? S_MEMWR : S_FETCH);
            end
            S_MEMRD: begin
                mrd_c = 1'b1;
                IorD  = 1'b1;
                if (mem_done) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rw_c    = 1'b1;
                GPRSel  = 2'b01;
                WDSel   = 2'b01;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                mwr_c = 1'b1;
                IorD  = 1'b1;
                if (mem_done) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = r_aluop;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rw_c    = 1'b1;
                ALUOp   = r_aluop;
                state_d = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                EXTOp   = (Op == OP_ADDI) || (Op == OP_SLTI);
                case (Op)
                    OP_ORI:  ALUOp = ALU_OR;
                    OP_LUI:  ALUOp = ALU_LUI;
                    OP_SLTI: ALUOp = ALU_SLT;
                    default: ALUOp = ALU_ADD;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                rw_c    = 1'b1;
                GPRSel  = 2'b01;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = 2'b01;
                pcw_c    = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                pcw_c    = 1'b1;
                if (Op == OP_JAL) begin
                    rw_c   = 1'b1;
                    GPRSel = 2'b10;
                    WDSel  = 2'b10;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are gated by rstn so a pending write dies the moment reset asserts.
    assign PCWrite  = rstn & pcw_c;
    assign IRWrite  = rstn & irw_c;
    assign RegWrite = rstn & rw_c;
    assign MemRead  = rstn & mrd_c;
    assign MemWrite = rstn & mwr_c;
    assign illegal  = rstn & ill_c;

    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && !ill_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_q + CNT_ONE;
            if (retire) instret_q <= instret_q + CNT_ONE;
        end
    end

    assign state_o     = state_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: a table of whole instructions checked cycle by cycle, then hand sequences
// for memory wait-states, FETCH stalls and reset during a store.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [5:0]  Op = 6'h00, Funct = 6'h20;
    logic        Zero = 1'b0, mem_rdy = 1'b1;
    logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp, ALUSrcA, illegal;
    logic [1:0]  ALUSrcB, PCSource, GPRSel, WDSel;
    logic [3:0]  ALUOp, state_o;
    logic [31:0] cycle_cnt, instret_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mc_ctrl dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_rdy(mem_rdy),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .GPRSel(GPRSel), .WDSel(WDSel), .illegal(illegal),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One instruction from FETCH back to FETCH with mem_rdy=1; bit k of the masks is cycle k.
    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [2:0]  len;
        logic [19:0] st;
        logic [4:0]  rw;
        logic [4:0]  pcw;
        logic [3:0]  alu2;
        logic [1:0]  pcs2;
        logic        ill;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                                input logic [2:0] len, input logic [19:0] st, input logic [4:0] rw,
                                input logic [4:0] pcw, input logic [3:0] alu2, input logic [1:0] pcs2,
                                input logic ill);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.len = len; v.st = st; v.rw = rw;
        v.pcw = pcw; v.alu2 = alu2; v.pcs2 = pcs2; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] c0, i0;
        logic [19:0] stv;
        logic [4:0]  rwv, pcwv;
        int          rw_pulses;

        vecs[0]  = mk(6'h00, 6'h20, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd1, 2'd0, 0); // add
        vecs[1]  = mk(6'h00, 6'h21, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd1, 2'd0, 0); // addu
        vecs[2]  = mk(6'h00, 6'h22, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd2, 2'd0, 0); // sub
        vecs[3]  = mk(6'h00, 6'h23, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd2, 2'd0, 0); // subu
        vecs[4]  = mk(6'h00, 6'h24, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd3, 2'd0, 0); // and
        vecs[5]  = mk(6'h00, 6'h25, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd4, 2'd0, 0); // or
        vecs[6]  = mk(6'h00, 6'h27, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd8, 2'd0, 0); // nor
        vecs[7]  = mk(6'h00, 6'h2A, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd5, 2'd0, 0); // slt
        vecs[8]  = mk(6'h00, 6'h2B, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd6, 2'd0, 0); // sltu
        vecs[9]  = mk(6'h00, 6'h00, 0, 4, 20'h07610, 5'b01000, 5'b00001, 4'd7, 2'd0, 0); // sll
        vecs[10] = mk(6'h08, 6'h3F, 0, 4, 20'h0BA10, 5'b01000, 5'b00001, 4'd1, 2'd0, 0); // addi
        vecs[11] = mk(6'h0D, 6'h00, 0, 4, 20'h0BA10, 5'b01000, 5'b00001, 4'd4, 2'd0, 0); // ori
        vecs[12] = mk(6'h0F, 6'h00, 0, 4, 20'h0BA10, 5'b01000, 5'b00001, 4'd8, 2'd0, 0); // lui
        vecs[13] = mk(6'h0A, 6'h00, 0, 4, 20'h0BA10, 5'b01000, 5'b00001, 4'd5, 2'd0, 0); // slti
        vecs[14] = mk(6'h23, 6'h00, 0, 5, 20'h43210, 5'b10000, 5'b00001, 4'd1, 2'd0, 0); // lw
        vecs[15] = mk(6'h2B, 6'h00, 0, 4, 20'h05210, 5'b00000, 5'b00001, 4'd1, 2'd0, 0); // sw
        vecs[16] = mk(6'h04, 6'h00, 1, 3, 20'h00810, 5'b00000, 5'b00101, 4'd2, 2'd1, 0); // beq taken
        vecs[17] = mk(6'h04, 6'h00, 0, 3, 20'h00810, 5'b00000, 5'b00001, 4'd2, 2'd1, 0); // beq not taken
        vecs[18] = mk(6'h05, 6'h00, 0, 3, 20'h00810, 5'b00000, 5'b00101, 4'd2, 2'd1, 0); // bne taken
        vecs[19] = mk(6'h05, 6'h00, 1, 3, 20'h00810, 5'b00000, 5'b00001, 4'd2, 2'd1, 0); // bne not taken
        vecs[20] = mk(6'h02, 6'h00, 0, 3, 20'h00910, 5'b00000, 5'b00101, 4'd0, 2'd2, 0); // j
        vecs[21] = mk(6'h03, 6'h00, 0, 3, 20'h00910, 5'b00100, 5'b00101, 4'd0, 2'd2, 0); // jal
        vecs[22] = mk(6'h3F, 6'h00, 0, 2, 20'h00010, 5'b00000, 5'b00001, 4'd0, 2'd0, 1); // bad op
        vecs[23] = mk(6'h00, 6'h3F, 0, 2, 20'h00010, 5'b00000, 5'b00001, 4'd0, 2'd0, 1); // bad funct

        // Reset state: FETCH, counters clear, enables forced low.
        #1;
        check("rst state", state_o, 0);
        check("rst memread", MemRead, 0);
        check("rst irwrite", IRWrite, 0);
        check("rst pcwrite", PCWrite, 0);
        repeat (3) @(negedge clk);
        check("rst cycle_cnt", cycle_cnt, 0);
        check("rst instret", instret_cnt, 0);
        rstn = 1'b1;
        #1;

        for (int i = 0; i < NV; i++) begin
            Op = vecs[i].op; Funct = vecs[i].funct; Zero = vecs[i].zero;
            stv = vecs[i].st; rwv = vecs[i].rw; pcwv = vecs[i].pcw;
            #1;
            c0 = cycle_cnt;
            i0 = instret_cnt;
            for (int k = 0; k < int'(vecs[i].len); k++) begin
                check($sformatf("v%0d k%0d state", i, k), state_o, stv[k*4 +: 4]);
                check($sformatf("v%0d k%0d regwrite", i, k), RegWrite, rwv[k]);
                check($sformatf("v%0d k%0d pcwrite", i, k), PCWrite, pcwv[k]);
                check($sformatf("v%0d k%0d illegal", i, k), illegal, (k == 1) ? vecs[i].ill : 1'b0);
                if (k == 2) begin
                    check($sformatf("v%0d aluop", i), ALUOp, vecs[i].alu2);
                    check($sformatf("v%0d pcsource", i), PCSource, vecs[i].pcs2);
                end
                step();
            end
            check($sformatf("v%0d end state", i), state_o, 0);
            check($sformatf("v%0d cycles", i), cycle_cnt - c0, vecs[i].len);
            check($sformatf("v%0d instret", i), instret_cnt - i0, vecs[i].ill ? 0 : 1);
        end

        // lw with two wait-states in MEMRD.
        Op = 6'h23; Funct = 6'h00; mem_rdy = 1'b1;
        i0 = instret_cnt;
        rw_pulses = 0;
        step(); step();
        check("lw memadr", state_o, 2);
        step();
        mem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_rdy = 1'b1;
            #1;
            check($sformatf("lw wait%0d state", k), state_o, 3);
            check($sformatf("lw wait%0d memread", k), MemRead, 1);
            check($sformatf("lw wait%0d iord", k), IorD, 1);
            if (RegWrite) rw_pulses++;
            step();
        end
        check("lw memwb state", state_o, 4);
        check("lw memwb wdsel", WDSel, 1);
        check("lw memwb gprsel", GPRSel, 1);
        if (RegWrite) rw_pulses++;
        step();
        check("lw regwrite pulses", rw_pulses, 1);
        check("lw back to fetch", state_o, 0);
        check("lw instret", instret_cnt - i0, 1);

        // FETCH stall while memory is not ready.
        Op = 6'h00; Funct = 6'h20;
        mem_rdy = 1'b0;
        #1;
        check("fetch stall irwrite", IRWrite, 0);
        check("fetch stall pcwrite", PCWrite, 0);
        check("fetch stall memread", MemRead, 1);
        step();
        check("fetch stall held", state_o, 0);
        mem_rdy = 1'b1;
        #1;
        check("fetch done irwrite", IRWrite, 1);
        check("fetch done pcwrite", PCWrite, 1);
        step();
        check("fetch done decode", state_o, 1);
        step(); step(); step();
        check("add after stall fetch", state_o, 0);

        // Reset asserted while a store waits in MEMWR.
        Op = 6'h2B;
        step(); step();
        mem_rdy = 1'b0;
        step();
        check("sw memwr state", state_o, 5);
        check("sw memwrite", MemWrite, 1);
        step();
        check("sw memwr held", state_o, 5);
        rstn = 1'b0;
        #1;
        check("rst memwrite drop", MemWrite, 0);
        check("rst mid state", state_o, 0);
        check("rst mid cycle_cnt", cycle_cnt, 0);
        check("rst mid instret", instret_cnt, 0);
        step();
        rstn = 1'b1;
        mem_rdy = 1'b1;
        #1;
        check("release state", state_o, 0);
        step();
        check("release next decode", state_o, 1);
        check("release cycle_cnt", cycle_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
